// File: rtl/shift_reg_n.sv
// shift_reg_n: mode-selectable shift register with parallel load and counted multi-shift FSM
module shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_input,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic             load,
    input  logic             shift_en,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_count,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       lmode;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sm;
    logic [WIDTH-1:0] nxt;
    logic             bout;

    // One-position shift of the current contents; a multi-shift uses the mode latched at start
    always_comb begin
        sm   = (state == SHIFT) ? lmode : mode;
        nxt  = (sm == 2'b00) ? {serial_input, parallel_out[WIDTH-1:1]} :
               (sm == 2'b01) ? {parallel_out[WIDTH-1], parallel_out[WIDTH-1:1]} :
               (sm == 2'b10) ? {parallel_out[WIDTH-2:0], serial_input} :
                               {parallel_out[0], parallel_out[WIDTH-1:1]};
        bout = (sm == 2'b10) ? parallel_out[WIDTH-1] : parallel_out[0];
    end

    // Register contents and control FSM; clear aborts any multi-shift without a done pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            parallel_out <= '0;
            serial_out   <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            lmode        <= 2'b00;
        end else if (clear) begin
            parallel_out <= '0;
            serial_out   <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        parallel_out <= parallel_in;
                    end else if (start) begin
                        lmode <= mode;
                        cnt   <= shift_count;
                        state <= (shift_count == '0) ? DONE : SHIFT;
                    end else if (shift_en) begin
                        parallel_out <= nxt;
                        serial_out   <= bout;
                    end
                end
                SHIFT: begin
                    parallel_out <= nxt;
                    serial_out   <= bout;
                    cnt          <= cnt - CNT_W'(cnt != '0);
                    if (cnt <= CNT_W'(1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_shift_reg_n.sv
// tb_shift_reg_n: directed and randomized checks of shift_reg_n against a behavioural model
module tb_shift_reg_n;
    localparam int W = 8;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic [W-1:0]  parallel_in = '0;
    logic          serial_input = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          clear = 1'b0;
    logic          load = 1'b0;
    logic          shift_en = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] shift_count = '0;
    logic [W-1:0]  parallel_out;
    logic          serial_out;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;

    logic [W-1:0] m_q = '0;
    logic         m_so = 1'b0;
    logic [1:0]   m_mode = 2'b00;
    int           m_rem = 0;
    bit           m_shift = 0;
    bit           m_done = 0;
    int           busy_cycles;

    shift_reg_n #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .parallel_in(parallel_in), .serial_input(serial_input),
        .mode(mode), .clear(clear), .load(load), .shift_en(shift_en), .start(start),
        .shift_count(shift_count), .parallel_out(parallel_out), .serial_out(serial_out),
        .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] mshift(input logic [W-1:0] d, input logic [1:0] m, input logic s);
        logic [W-1:0] top;
        top = s ? 8'h80 : 8'h00;
        case (m)
            2'b00:   return {d[0], (d >> 1) | top};
            2'b01:   return {d[0], W'($signed(d) >>> 1)};
            2'b10:   return {d[W-1], W'((d << 1) | W'(s))};
            default: return {d[0], (d >> 1) | (d[0] ? 8'h80 : 8'h00)};
        endcase
    endfunction

    task automatic model();
        logic [W:0] r;
        if (Reset) begin
            m_q = '0; m_so = 0; m_rem = 0; m_shift = 0; m_done = 0;
        end else if (clear) begin
            m_q = '0; m_so = 0; m_rem = 0; m_shift = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_shift) begin
            r = mshift(m_q, m_mode, serial_input);
            {m_so, m_q} = r;
            m_rem--;
            if (m_rem == 0) begin
                m_shift = 0;
                m_done = 1;
            end
        end else if (load) begin
            m_q = parallel_in;
        end else if (start) begin
            m_mode = mode;
            m_rem = int'(shift_count);
            if (m_rem == 0) m_done = 1;
            else m_shift = 1;
        end else if (shift_en) begin
            r = mshift(m_q, mode, serial_input);
            {m_so, m_q} = r;
        end
    endtask

    task automatic step(input logic rs, input logic cl, input logic ld, input logic st, input logic se,
                        input logic [1:0] md, input logic si, input logic [W-1:0] pin, input logic [CW-1:0] cnt);
        Reset = rs; clear = cl; load = ld; start = st; shift_en = se;
        mode = md; serial_input = si; parallel_in = pin; shift_count = cnt;
        @(posedge Clk);
        model();
        #1;
        chk("q", parallel_out, m_q);
        chk("so", serial_out, m_so);
        chk("busy", busy, m_shift || m_done);
        chk("done", done, m_done);
        if (busy) busy_cycles++;
    endtask

    task automatic idle(input logic [1:0] md, input logic si);
        step(0, 0, 0, 0, 0, md, si, W'($urandom), CW'($urandom));
    endtask

    initial begin
        // reset with random other inputs
        step(1, $urandom, $urandom, $urandom, $urandom, 2'($urandom), $urandom, W'($urandom), CW'($urandom));
        chk("rst_q", parallel_out, 8'h00);
        chk("rst_so", serial_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);

        // load + single shifts
        step(0, 0, 1, 0, 0, 2'b00, 0, 8'hA5, 0);
        chk("load", parallel_out, 8'hA5);
        step(0, 0, 0, 0, 1, 2'b00, 1, 8'h00, 0);
        chk("lsr", parallel_out, 8'hD2);
        chk("lsr_so", serial_out, 1'b1);
        step(0, 0, 0, 0, 1, 2'b10, 0, 8'h00, 0);
        chk("lsl", parallel_out, 8'hA4);
        chk("lsl_so", serial_out, 1'b1);

        // arithmetic multi-shift by 3, live mode differs from latched mode
        step(0, 0, 1, 0, 0, 2'b00, 0, 8'h96, 0);
        busy_cycles = 0;
        step(0, 0, 0, 1, 0, 2'b01, 0, 8'h00, 4'd3);
        chk("e0_q", parallel_out, 8'h96);
        idle(2'b10, 0);
        chk("e1", parallel_out, 8'hCB);
        idle(2'b10, 0);
        chk("e2", parallel_out, 8'hE5);
        idle(2'b10, 0);
        chk("e3", parallel_out, 8'hF2);
        chk("e3_so", serial_out, 1'b1);
        chk("e3_done", done, 1'b1);
        idle(2'b00, 0);
        chk("after_done", done, 1'b0);
        chk("busy_len", 64'(busy_cycles), 64'd4);

        // rotate by 4 then zero-count start
        step(0, 0, 1, 0, 0, 2'b00, 0, 8'h81, 0);
        step(0, 0, 0, 1, 0, 2'b11, 0, 8'h00, 4'd4);
        repeat (4) idle(2'b00, 1);
        chk("rot", parallel_out, 8'h18);
        chk("rot_so", serial_out, 1'b0);
        idle(2'b00, 0);
        step(0, 0, 0, 1, 0, 2'b11, 0, 8'h00, 4'd0);
        chk("zero_done", done, 1'b1);
        chk("zero_q", parallel_out, 8'h18);
        idle(2'b00, 0);

        // load ignored while busy, clear aborts without done
        step(0, 0, 0, 1, 0, 2'b00, 1, 8'h00, 4'd5);
        idle(2'b00, 1);
        idle(2'b00, 0);
        step(0, 0, 1, 0, 0, 2'b00, 1, 8'h5A, 0);
        chk("ld_ign", parallel_out == 8'h5A, 1'b0);
        step(0, 1, 0, 0, 0, 2'b00, 0, 8'h00, 0);
        chk("clr_q", parallel_out, 8'h00);
        chk("clr_busy", busy, 1'b0);
        idle(2'b00, 0);
        chk("clr_nodone", done, 1'b0);

        // reset mid-shift, then a normal single-position start
        step(0, 0, 1, 0, 0, 2'b00, 0, 8'h3C, 0);
        step(0, 0, 0, 1, 0, 2'b10, 1, 8'h00, 4'd6);
        idle(2'b00, 1);
        step(1, 0, 0, 0, 0, 2'b00, 1, 8'h00, 0);
        chk("midrst_q", parallel_out, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        step(0, 0, 0, 1, 0, 2'b00, 1, 8'h00, 4'd1);
        idle(2'b00, 1);
        chk("s1_q", parallel_out, 8'h80);
        chk("s1_done", done, 1'b1);
        idle(2'b00, 0);
        chk("s1_idle", busy, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom % 60) == 0, ($urandom % 25) == 0, ($urandom % 6) == 0, ($urandom % 5) == 0,
                 $urandom, 2'($urandom), $urandom, W'($urandom), CW'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_reg_n.md
SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the shift-count width.
REQ-003 The port Clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 The port Reset SHALL be an input, 1 bit wide, and is a synchronous, active-high reset.
REQ-005 The port parallel_in SHALL be an input, WIDTH bits wide, carrying the parallel load data.
REQ-006 The port serial_input SHALL be an input, 1 bit wide, carrying the fill bit for logical right and left shifts.
REQ-007 The port mode SHALL be an input, 2 bits wide: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
REQ-008 The port clear SHALL be an input, 1 bit wide, acting as a functional clear and an abort of any multi-shift.
REQ-009 The port load SHALL be an input, 1 bit wide, loading parallel_in.
REQ-010 The port shift_en SHALL be an input, 1 bit wide, requesting a single shift this cycle.
REQ-011 The port start SHALL be an input, 1 bit wide, requesting a multi-shift of shift_count positions.
REQ-012 The port shift_count SHALL be an input, CNT_W bits wide, giving the number of positions for start.
REQ-013 The port parallel_out SHALL be an output, WIDTH bits wide, carrying the registered contents.
REQ-014 The port serial_out SHALL be an output, 1 bit wide, registered, holding the last bit shifted out.
REQ-015 The port busy SHALL be an output, 1 bit wide, high whenever the FSM is not in IDLE.
REQ-016 The port done SHALL be an output, 1 bit wide, a one-cycle pulse on completion of a multi-shift.

Function
REQ-017 A single shift SHALL apply as follows, with D = contents and s = serial_input:
- 00: {s, D[W-1:1]}, bit out D[0]
- 01: {D[W-1], D[W-1:1]}, bit out D[0]
- 10: {D[W-2:0], s}, bit out D[W-1]
- 11: {D[0], D[W-1:1]}, bit out D[0]
REQ-018 Each shift SHALL update serial_out with its bit out; any other operation SHALL leave serial_out unchanged, except clear, which sets it to 0.
REQ-019 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, and SHALL start in IDLE.
REQ-020 In IDLE, priority SHALL be clear > load > start > shift_en; only the highest-priority asserted request acts that edge.
REQ-021 In IDLE, clear SHALL set parallel_out and serial_out to 0; load SHALL set parallel_out to parallel_in; shift_en SHALL perform one shift per the live mode; every one of these SHALL have 1-edge latency and leave the state in IDLE.
REQ-022 In IDLE, start at edge E0 with N = shift_count and N ≥ 1 SHALL latch mode and N, and go to SHIFT; parallel_out SHALL be unchanged at E0.
REQ-023 In SHIFT, one shift (latched mode, live serial_input) SHALL occur on each of edges E1..EN, after which the state SHALL go to DONE at EN.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE at the next edge.
REQ-025 start with shift_count = 0 SHALL go directly to DONE at E0 with contents unchanged.
REQ-026 shift_count values above WIDTH SHALL be honoured literally, with no clamping; logical modes therefore end fully filled, and rotate wraps.
REQ-027 While busy, load, start and shift_en SHALL be ignored, not queued.
REQ-028 While busy, clear SHALL zero parallel_out and serial_out and force IDLE at that edge; no done pulse SHALL follow.
REQ-029 The remaining-shift counter SHALL be CNT_W bits, SHALL decrement once per shift, and SHALL never wrap below 0.

Reset
REQ-030 Reset = 1 at an edge SHALL set parallel_out = 0, serial_out = 0, state = IDLE, busy = 0, done = 0 and counter = 0, overriding all other inputs in any state, including mid-SHIFT.
REQ-031 Outputs SHALL be valid and stable from the first edge with Reset asserted; no asynchronous path SHALL exist.

Verification (WIDTH=8)
REQ-032 The bench SHALL cover: Reset for 1 cycle with random inputs -> parallel_out=8'h00, serial_out=0, busy=0, done=0.
REQ-033 The bench SHALL cover: load 8'hA5, then shift_en, mode 00, serial_input=1 -> 8'hD2, serial_out=1; then mode 10, serial_input=0 -> 8'hA4, serial_out=1.
REQ-034 The bench SHALL cover: load 8'h96, start with count 3, mode 01 -> CB, E5, F2 at E1..E3; done high one cycle after E3; busy high 4 cycles; serial_out=1.
REQ-035 The bench SHALL cover: load 8'h81, start with count 4, mode 11 -> 8'h18, serial_out=0; then start with count 0 -> done next cycle, value 8'h18 unchanged.
REQ-036 The bench SHALL cover: start with count 5, mode 00, after E2 assert load=1 (ignored), after E3 assert clear -> 8'h00, busy=0 next cycle, no done.
REQ-037 The bench SHALL cover: start with count 6, then Reset at E2 -> all outputs at reset values; a subsequent start with count 1 completes normally.
